// File: rtl/change_dispenser_if.sv
// Coin hopper handshake: four-phase request/acknowledge
// with the denomination to eject.
interface change_dispenser_if;
    logic       coinReq;
    logic [2:0] coinSel;
    logic       coinAck;

    modport master (
        output coinReq,
        output coinSel,
        input  coinAck
    );

    modport slave (
        input  coinReq,
        input  coinSel,
        output coinAck
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: ejects the largest affordable coin in stock,
// one four-phase hopper handshake per coin, with per-phase timeout.
module change_dispenser #(
    parameter int STOCK_INIT  = 20,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                start,
    input  logic [9:0]          amount,
    input  logic                restock,
    change_dispenser_if.master  hopper,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [9:0]          remaining,
    output logic [6:0]          coinsOut
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [5:0] INIT = 6'(STOCK_INIT);
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, PICK, REQ, RELEASE, FINISH, ERR
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [5:0]    stock [5];
    logic [CW-1:0] phaseCnt;
    logic [2:0]    sel;
    logic [2:0]    pickSel;
    logic          pickOk;
    logic          badAmount;
    logic          timeout;
    logic          errorQ;

    function automatic logic [9:0] coinValue(input logic [2:0] s);
        case (s)
            3'd0:    coinValue = 10'd5;
            3'd1:    coinValue = 10'd10;
            3'd2:    coinValue = 10'd25;
            3'd3:    coinValue = 10'd50;
            default: coinValue = 10'd100;
        endcase
    endfunction

    assign badAmount = (amount > 10'd500) || ((amount % 10'd5) != 10'd0);
    assign timeout   = (phaseCnt == LAST);

    // Ascending scan: the last hit is the largest usable denomination.
    always_comb begin
        pickOk  = 1'b0;
        pickSel = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (stock[i] != 6'd0 && coinValue(3'(i)) <= remaining) begin
                pickOk  = 1'b1;
                pickSel = 3'(i);
            end
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start)
                    stateNext = badAmount ? ERR : PICK;
            end
            PICK: begin
                if (remaining == 10'd0)
                    stateNext = FINISH;
                else if (pickOk)
                    stateNext = REQ;
                else
                    stateNext = ERR;
            end
            REQ: begin
                if (hopper.coinAck)
                    stateNext = RELEASE;
                else if (timeout)
                    stateNext = ERR;
            end
            RELEASE: begin
                if (!hopper.coinAck)
                    stateNext = PICK;
                else if (timeout)
                    stateNext = ERR;
            end
            FINISH:  stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sel       <= 3'd0;
            errorQ    <= 1'b0;
            remaining <= 10'd0;
            coinsOut  <= 7'd0;
            phaseCnt  <= '0;
            for (int i = 0; i < 5; i++)
                stock[i] <= INIT;
        end else begin
            // Counter restarts whenever a handshake phase is (re)entered.
            if ((state == REQ || state == RELEASE) && stateNext == state)
                phaseCnt <= phaseCnt + 1'b1;
            else
                phaseCnt <= '0;

            if (stateNext == ERR)
                errorQ <= 1'b1;
            else if (state == IDLE && start)
                errorQ <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (restock)
                        for (int i = 0; i < 5; i++)
                            stock[i] <= INIT;
                    if (start) begin
                        remaining <= amount;
                        coinsOut  <= 7'd0;
                    end
                end
                PICK: begin
                    if (pickOk && remaining != 10'd0)
                        sel <= pickSel;
                end
                REQ: begin
                    if (hopper.coinAck) begin
                        remaining  <= remaining - coinValue(sel);
                        stock[sel] <= stock[sel] - 6'd1;
                        coinsOut   <= coinsOut + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hopper.coinReq = (state == REQ);
    assign hopper.coinSel = sel;
    assign busy  = (state != IDLE);
    assign done  = (state == FINISH) || (state == ERR);
    assign error = errorQ;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (full and single-coin stock)
// checked every cycle against a greedy transaction-level model.
module tb_change_dispenser;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic       restock;
    logic [9:0] amount;
    logic       holdAck;
    logic       manualAck [2];

    logic       req   [2];
    logic [2:0] sel   [2];
    logic       ack   [2];
    logic       busy  [2];
    logic       done  [2];
    logic       error [2];
    logic [9:0] rem   [2];
    logic [6:0] cnt   [2];

    always #5 clk = ~clk;

    change_dispenser_if hA ();
    change_dispenser_if hB ();

    assign req[0] = hA.coinReq;
    assign sel[0] = hA.coinSel;
    assign req[1] = hB.coinReq;
    assign sel[1] = hB.coinSel;
    assign ack[0] = holdAck ? manualAck[0] : req[0];
    assign ack[1] = holdAck ? manualAck[1] : req[1];
    assign hA.coinAck = ack[0];
    assign hB.coinAck = ack[1];

    change_dispenser #(.STOCK_INIT(20), .ACK_TIMEOUT(TO)) dutA (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .amount    (amount),
        .restock   (restock),
        .hopper    (hA),
        .busy      (busy[0]),
        .done      (done[0]),
        .error     (error[0]),
        .remaining (rem[0]),
        .coinsOut  (cnt[0])
    );

    change_dispenser #(.STOCK_INIT(1), .ACK_TIMEOUT(TO)) dutB (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .amount    (amount),
        .restock   (restock),
        .hopper    (hB),
        .busy      (busy[1]),
        .done      (done[1]),
        .error     (error[1]),
        .remaining (rem[1]),
        .coinsOut  (cnt[1])
    );

    int checks = 0;
    int fails  = 0;

    function automatic void chk(input string name, input int inst,
                                input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d, expected %0d",
                     name, inst, act, exp);
        end
    endfunction

    function automatic int val(input int d);
        case (d)
            0:       return 5;
            1:       return 10;
            2:       return 25;
            3:       return 50;
            default: return 100;
        endcase
    endfunction

    int initStock [2] = '{20, 1};
    int mStock  [2][5];
    bit mIdle   [2];
    bit mErr    [2];
    bit mErrFin [2];
    bit mTimeout[2];
    int mRem    [2];
    int mCnt    [2];
    int mRemFin [2];
    int mCntFin [2];
    int plan    [2][128];
    int planLen [2];
    int planPos [2];
    int curVal  [2];
    bit prevReq [2];
    int reqRun  [2];
    int seqLog  [2][16];
    int seqLen  [2];

    // Work out the whole transaction up front from the greedy rule.
    task automatic accept(input int i, input int amt);
        int r;
        int n;
        int best;
        int s [5];
        bit stuck;
        seqLen[i]   = 0;
        planPos[i]  = 0;
        planLen[i]  = 0;
        mRem[i]     = amt;
        mCnt[i]     = 0;
        mErr[i]     = 1'b0;
        mTimeout[i] = 1'b0;
        if (amt > 500 || amt % 5 != 0) begin
            mErrFin[i] = 1'b1;
            mRemFin[i] = amt;
            mCntFin[i] = 0;
        end else begin
            for (int d = 0; d < 5; d++)
                s[d] = mStock[i][d];
            r = amt;
            n = 0;
            stuck = 1'b0;
            while (r > 0 && !stuck) begin
                best = -1;
                for (int d = 4; d >= 0; d--) begin
                    if (val(d) <= r && s[d] > 0) begin
                        best = d;
                        break;
                    end
                end
                if (best < 0) begin
                    stuck = 1'b1;
                end else begin
                    plan[i][n] = best;
                    n++;
                    s[best]--;
                    r -= val(best);
                end
            end
            if (holdAck && n > 0) begin
                planLen[i]  = 1;
                mTimeout[i] = 1'b1;
                mErrFin[i]  = 1'b1;
                mRemFin[i]  = amt;
                mCntFin[i]  = 0;
            end else begin
                planLen[i] = n;
                mErrFin[i] = stuck;
                mRemFin[i] = r;
                mCntFin[i] = n;
                for (int d = 0; d < 5; d++)
                    mStock[i][d] = s[d];
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetN) begin
                chk("rstBusy", i, busy[i], 0);
                chk("rstReq", i, req[i], 0);
                chk("rstDone", i, done[i], 0);
                chk("rstRem", i, rem[i], 0);
                chk("rstCnt", i, cnt[i], 0);
                chk("rstErr", i, error[i], 0);
                mIdle[i]   = 1'b1;
                mErr[i]    = 1'b0;
                mRem[i]    = 0;
                mCnt[i]    = 0;
                prevReq[i] = 1'b0;
                planLen[i] = 0;
                planPos[i] = 0;
                for (int d = 0; d < 5; d++)
                    mStock[i][d] = initStock[i];
            end else begin
                chk("busy", i, busy[i], !mIdle[i]);
                if (mIdle[i])
                    chk("reqWhileIdle", i, req[i], 0);
                if (req[i] && !prevReq[i]) begin
                    chk("coinReqPlanned", i, planPos[i] < planLen[i], 1);
                    if (planPos[i] < planLen[i]) begin
                        chk("coinSel", i, sel[i], plan[i][planPos[i]]);
                        curVal[i] = val(plan[i][planPos[i]]);
                        planPos[i]++;
                    end
                    if (seqLen[i] < 16) begin
                        seqLog[i][seqLen[i]] = sel[i];
                        seqLen[i]++;
                    end
                    reqRun[i] = 0;
                end
                if (req[i])
                    reqRun[i]++;
                chk("remaining", i, rem[i], mRem[i]);
                chk("coinsOut", i, cnt[i], mCnt[i]);
                if (done[i]) begin
                    chk("doneWhileBusy", i, mIdle[i], 0);
                    chk("finalErr", i, error[i], mErrFin[i]);
                    chk("finalRem", i, rem[i], mRemFin[i]);
                    chk("finalCnt", i, cnt[i], mCntFin[i]);
                    chk("coinsIssued", i, planPos[i], planLen[i]);
                    if (mTimeout[i])
                        chk("reqCycles", i, reqRun[i], TO);
                    mErr[i]  = mErrFin[i];
                    mIdle[i] = 1'b1;
                end else begin
                    chk("error", i, error[i], mErr[i]);
                    if (req[i] && ack[i]) begin
                        mRem[i] -= curVal[i];
                        mCnt[i]++;
                    end
                    if (mIdle[i] && restock)
                        for (int d = 0; d < 5; d++)
                            mStock[i][d] = initStock[i];
                    if (mIdle[i] && start) begin
                        accept(i, int'(amount));
                        mIdle[i] = 1'b0;
                    end
                end
                prevReq[i] = req[i];
            end
        end
    end

    int doneAt [2];

    task automatic runTxn(input int amt, input bit rs, input bit extra);
        int k;
        @(posedge clk);
        #1;
        start   = 1'b1;
        restock = rs;
        amount  = 10'(amt);
        @(posedge clk);
        #1;
        start   = 1'b0;
        restock = 1'b0;
        doneAt  = '{-1, -1};
        k = 0;
        while (1) begin
            @(negedge clk);
            k++;
            for (int i = 0; i < 2; i++)
                if (done[i] && doneAt[i] < 0)
                    doneAt[i] = k;
            if (!busy[0] && !busy[1])
                break;
            if (k >= 400) begin
                chk("txnBudget", 0, k, -1);
                break;
            end
            @(posedge clk);
            #1;
            if (extra && k == 1) begin
                start  = 1'b1;
                amount = 10'd500;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        #2;
    endtask

    task automatic expectSeq(input int i, input int n,
                             input int c0, input int c1,
                             input int c2, input int c3);
        int exp [4];
        exp = '{c0, c1, c2, c3};
        chk("seqLen", i, seqLen[i], n);
        for (int j = 0; j < n && j < 4 && j < seqLen[i]; j++)
            chk("seqCoin", i, seqLog[i][j], exp[j]);
    endtask

    task automatic expectEnd(input int i, input int r,
                             input int c, input int e);
        chk("litRem", i, rem[i], r);
        chk("litCnt", i, cnt[i], c);
        chk("litErr", i, error[i], e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetN    = 1'b0;
        start     = 1'b0;
        restock   = 1'b0;
        amount    = 10'd0;
        holdAck   = 1'b0;
        manualAck = '{1'b0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("resetSel", i, sel[i], 0);
            expectEnd(i, 0, 0, 0);
        end
        resetN = 1'b1;

        runTxn(90, 1'b1, 1'b0);
        expectSeq(0, 4, 3, 2, 1, 0);
        expectEnd(0, 0, 4, 0);
        expectSeq(1, 4, 3, 2, 1, 0);

        runTxn(60, 1'b1, 1'b0);
        expectSeq(1, 2, 3, 1, 0, 0);
        expectEnd(1, 0, 2, 0);
        runTxn(60, 1'b0, 1'b0);
        expectSeq(1, 2, 2, 0, 0, 0);
        expectEnd(1, 30, 2, 1);
        expectEnd(0, 0, 2, 0);

        runTxn(7, 1'b0, 1'b0);
        chk("errLatency", 0, doneAt[0] >= 1 && doneAt[0] <= 2, 1);
        expectSeq(0, 0, 0, 0, 0, 0);
        expectEnd(0, 7, 0, 1);

        runTxn(505, 1'b0, 1'b0);
        expectEnd(0, 505, 0, 1);
        runTxn(500, 1'b0, 1'b0);
        expectEnd(0, 0, 5, 0);
        expectEnd(1, 400, 1, 1);

        holdAck = 1'b1;
        runTxn(25, 1'b1, 1'b0);
        chk("timeoutReqCycles", 0, reqRun[0], TO);
        expectEnd(0, 25, 0, 1);
        holdAck = 1'b0;
        runTxn(25, 1'b0, 1'b0);
        expectSeq(1, 1, 2, 0, 0, 0);
        expectEnd(1, 0, 1, 0);

        runTxn(15, 1'b0, 1'b1);
        expectSeq(0, 2, 1, 0, 0, 0);
        expectEnd(0, 0, 2, 0);
        expectSeq(1, 2, 1, 0, 0, 0);

        holdAck = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b1;
        amount = 10'd25;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req[0])
                break;
        end
        chk("reqSeen", 0, req[0], 1);
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b0;
        #1;
        chk("reqDropOnReset", 0, req[0], 0);
        chk("busyDropOnReset", 0, busy[0], 0);
        chk("selOnReset", 0, sel[0], 0);
        @(posedge clk);
        #1;
        resetN    = 1'b1;
        manualAck = '{1'b1, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        manualAck = '{1'b0, 1'b0};
        expectEnd(0, 0, 0, 0);
        chk("busyAfterStrayAck", 0, busy[0], 0);
        holdAck = 1'b0;
        runTxn(60, 1'b0, 1'b0);
        expectSeq(1, 2, 3, 1, 0, 0);
        expectEnd(1, 0, 2, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter STOCK_INIT, default 20, coins loaded per denomination at reset/restock (max 63).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1000, clock cycles allowed per handshake phase before error.
REQ-003 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have resetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have start  input  1  request to dispense amount; sampled only in IDLE.
REQ-006 SHALL have amount  input  10  change in cents, unsigned.
REQ-007 SHALL have restock  input  1  reload all stock counters to STOCK_INIT; honoured only in IDLE.
REQ-008 SHALL have coinAck  input  1  hopper acknowledge, four-phase.
REQ-009 SHALL have coinReq  output  1  request hopper to eject one coin of coinSel.
REQ-010 SHALL have coinSel  output  3  denomination: 0 nickel, 1 dime, 2 quarter, 3 fifty, 4 dollar.
REQ-011 SHALL have busy  output  1  transaction in progress.
REQ-012 SHALL have done  output  1  one-cycle end-of-transaction pulse.
REQ-013 SHALL have error  output  1  last transaction failed; held until next accepted start.
REQ-014 SHALL have remaining  output  10  cents not yet dispensed.
REQ-015 SHALL have coinsOut  output  7  coins dispensed in current/last transaction.

Function
REQ-016 SHALL implement states IDLE, PICK, REQ, RELEASE, FINISH, ERR.
REQ-017 IDLE, start=1: SHALL latch amount into remaining, clear coinsOut and error, set busy, go PICK next edge.
REQ-018 IDLE, start=1 with amount >500 or amount mod 5 != 0: SHALL go ERR, remaining=amount, no coinReq ever asserted.
REQ-019 start while busy SHALL be ignored; restock and start together in IDLE: restock applied, then transaction uses reloaded stock.
REQ-020 PICK (one cycle): remaining==0 -> FINISH; else select largest denomination with value <= remaining and stock > 0 -> REQ; none -> ERR.
REQ-021 coinSel SHALL be registered in PICK and held stable through REQ and RELEASE.
REQ-022 REQ: coinReq=1; on coinAck=1 SHALL subtract coin value from remaining, decrement that stock, increment coinsOut, drop coinReq next edge, go RELEASE.
REQ-023 RELEASE: coinReq=0; SHALL wait for coinAck=0 then go PICK; a new coinReq SHALL never rise while coinAck=1.
REQ-024 A per-phase cycle counter SHALL clear on entry to REQ and RELEASE; reaching ACK_TIMEOUT in either SHALL go ERR with remaining/stock unchanged by that phase.
REQ-025 FINISH: done=1 one cycle, busy=0 next edge, error=0, go IDLE.
REQ-026 ERR: done=1 and error=1 one cycle, coinReq=0, busy=0 next edge, go IDLE; remaining holds undispensed residue.
REQ-027 Stock counters SHALL never underflow; a denomination with stock 0 SHALL never be selected.
REQ-028 remaining arithmetic SHALL be 10-bit unsigned, never negative by construction of REQ-020.
REQ-029 Minimum cost per coin SHALL be 3 cycles (PICK, REQ with immediate ack, RELEASE with immediate release).

Reset
REQ-030 resetN=0 at any time SHALL immediately force IDLE, coinReq=0, coinSel=0, busy=0, done=0, error=0, remaining=0, coinsOut=0, all stocks=STOCK_INIT, timeout counter=0.
REQ-031 Reset mid-REQ SHALL abandon the coin with no stock decrement; a coinAck arriving during or after reset SHALL be ignored until a new REQ.

Verification
REQ-032 Full stock, start amount=90, immediate acks -> coinSel sequence 3,2,1,2 is wrong; required 3,2,1,0 (50,25,10,5), done pulse, remaining=0, coinsOut=4, error=0.
REQ-033 STOCK_INIT=1: amount=60 -> 50,10, success; then amount=60 -> 25,5 then ERR, remaining=30, coinsOut=2, error=1.
REQ-034 amount=7 -> ERR within 2 cycles, coinReq never high, remaining=7, error=1.
REQ-035 amount=25, coinAck held 0 -> coinReq high exactly ACK_TIMEOUT cycles, then ERR, remaining=25, quarter stock unchanged.
REQ-036 resetN pulsed low while coinReq=1 -> coinReq=0 same instant, busy=0, stocks=STOCK_INIT; subsequent coinAck causes no change.
REQ-037 start pulsed again with amount=500 during a busy amount=15 transaction -> ignored, 15 dispensed as 10,5, remaining=0.
